// File: rtl/j1x_pkg.sv
// Shared definitions for the j1x stack CPU: instruction classes, ALU field
// positions, ALU op codes and the bus-stall FSM state type.
package j1x_pkg;

  // Instruction class, insn[W-1:W-3]. Any value with the top bit set is a literal.
  localparam logic [2:0] CLS_JUMP    = 3'b000;
  localparam logic [2:0] CLS_ZBRANCH = 3'b001;
  localparam logic [2:0] CLS_CALL    = 3'b010;
  localparam logic [2:0] CLS_ALU     = 3'b011;

  // Single-bit fields of an ALU instruction.
  localparam int BIT_R2PC  = 12;
  localparam int BIT_T2N   = 7;
  localparam int BIT_T2R   = 6;
  localparam int BIT_STORE = 5;

  typedef enum logic [3:0] {
    OP_T     = 4'h0,
    OP_N     = 4'h1,
    OP_ADD   = 4'h2,
    OP_AND   = 4'h3,
    OP_OR    = 4'h4,
    OP_XOR   = 4'h5,
    OP_INV   = 4'h6,
    OP_EQ    = 4'h7,
    OP_LT    = 4'h8,
    OP_RSH   = 4'h9,
    OP_DEC   = 4'hA,
    OP_R     = 4'hB,
    OP_LOAD  = 4'hC,
    OP_LSH   = 4'hD,
    OP_DEPTH = 4'hE,
    OP_ULT   = 4'hF
  } alu_op_e;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/j1x_stack.sv
// Register-file LIFO used for both the data and return stacks. The top entry
// is read combinationally at the pointer; the pointer wraps modulo depth and
// sticky flags record pushes past the top and pops below the bottom.
module j1x_stack #(
  parameter int WIDTH     = 32,
  parameter int DEPTH_LG2 = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 we,
  input  logic [1:0]           delta,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     top,
  output logic [DEPTH_LG2-1:0] ptr,
  output logic                 ovf,
  output logic                 unf
);

  logic [WIDTH-1:0]     mem [2**DEPTH_LG2];
  logic [DEPTH_LG2-1:0] ptr_next;

  // Two's-complement delta sign-extended to the pointer width.
  assign ptr_next = ptr + DEPTH_LG2'($signed(delta));
  assign top      = mem[ptr];

  // Entry write lands at the post-move pointer so a push fills the new slot.
  // NOTE: the storage array carries no reset; only the pointer defines which
  // entries are meaningful, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (en && we) mem[ptr_next] <= wdata;
  end

  // Pointer movement and sticky overflow/underflow detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (en) begin
      ptr <= ptr_next;
      if (delta == 2'b01 && (&ptr)) ovf <= 1'b1;
      if ((delta == 2'b11 && ptr == '0) ||
          (delta == 2'b10 && ptr < DEPTH_LG2'(2))) unf <= 1'b1;
    end
  end

endmodule

// File: rtl/j1x_core.sv
// j1x_core: parametrised j1-class stack CPU with a synchronous code ROM, a
// ready-handshaked data/IO bus and sticky stack fault flags.
// Optional interrupt support is compiled in with `define J1X_IRQ_EN.
module j1x_core
  import j1x_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 14,
  parameter int DSTK_LG2 = 5,
  parameter int RSTK_LG2 = 5
`ifdef J1X_IRQ_EN
  , parameter int IRQ_VEC = 1
`endif
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_n_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [WIDTH-1:0]  imem_data_i,
  output logic [ADDR_W-1:0] dbus_addr_o,
  output logic [WIDTH-1:0]  dbus_wdata_o,
  output logic              dbus_re_o,
  output logic              dbus_we_o,
  input  logic              dbus_ready_i,
  input  logic [WIDTH-1:0]  dbus_rdata_i,
  output logic              dstk_ovf_o,
  output logic              dstk_unf_o,
  output logic              rstk_ovf_o,
  output logic              rstk_unf_o
`ifdef J1X_IRQ_EN
  , input logic             irq_i
`endif
);

  logic                rst_n;
  logic [WIDTH-1:0]    insn;
  logic [2:0]          cls;
  logic                is_lit, is_alu, is_call;
  alu_op_e             op;
  logic [ADDR_W-1:0]   target;

  logic [ADDR_W-1:0]   pc, pc_next, pc_plus1;
  logic [WIDTH-1:0]    t, t_next, n, r, alu, shamt;
  logic [DSTK_LG2-1:0] dsp;
  logic [RSTK_LG2-1:0] rsp;
  state_e              state;

  logic                bus_rd, bus_wr, bus_req, retire, irq_take;
  logic [1:0]          d_delta, r_delta;
  logic                d_we, r_we;
  logic [WIDTH-1:0]    r_wdata;

  assign rst_n    = sys_rst_n_i;
  assign insn     = imem_data_i;
  assign cls      = insn[WIDTH-1:WIDTH-3];
  assign is_lit   = insn[WIDTH-1];
  assign is_alu   = (cls == CLS_ALU);
  assign is_call  = (cls == CLS_CALL);
  assign op       = alu_op_e'(insn[11:8]);
  assign target   = insn[ADDR_W-1:0];
  assign pc_plus1 = pc + ADDR_W'(1);
  assign shamt    = t % WIDTH'(WIDTH);

  // Requests are gated by reset so an aborted access drops immediately.
  assign bus_rd       = rst_n && is_alu && (op == OP_LOAD);
  assign bus_wr       = rst_n && is_alu && insn[BIT_STORE];
  assign bus_req      = bus_rd || bus_wr;
  assign dbus_re_o    = bus_rd;
  assign dbus_we_o    = bus_wr;
  assign dbus_addr_o  = t[ADDR_W-1:0];
  assign dbus_wdata_o = n;

  // In WAIT the held instruction always has a request, so only ready matters.
  assign retire = (state == ST_RUN) ? (!bus_req || dbus_ready_i) : dbus_ready_i;

`ifdef J1X_IRQ_EN
  localparam int BIT_RETI = 4;
  logic ie, after_call;
  assign irq_take = rst_n && (state == ST_RUN) && irq_i && ie && !bus_req &&
                    !(is_lit && after_call);
`else
  assign irq_take = 1'b0;
`endif

  // ALU result for the current T/N/R operands.
  always_comb begin
    alu = t;
    unique case (op)
      OP_T:     alu = t;
      OP_N:     alu = n;
      OP_ADD:   alu = t + n;
      OP_AND:   alu = t & n;
      OP_OR:    alu = t | n;
      OP_XOR:   alu = t ^ n;
      OP_INV:   alu = ~t;
      OP_EQ:    alu = {WIDTH{n == t}};
      OP_LT:    alu = {WIDTH{$signed(n) < $signed(t)}};
      OP_RSH:   alu = n >> shamt;
      OP_DEC:   alu = t - WIDTH'(1);
      OP_R:     alu = r;
      OP_LOAD:  alu = dbus_rdata_i;
      OP_LSH:   alu = n << shamt;
      OP_DEPTH: alu = WIDTH'({rsp, dsp});
      OP_ULT:   alu = {WIDTH{n < t}};
    endcase
  end

  // Instruction decode into next T, next PC and stack moves.
  // NOTE: every output is given a default first so no path leaves a value
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    t_next  = t;
    pc_next = pc_plus1;
    d_delta = 2'b00;
    d_we    = 1'b0;
    r_delta = 2'b00;
    r_we    = 1'b0;
    r_wdata = t;
    if (irq_take) begin
`ifdef J1X_IRQ_EN
      pc_next = ADDR_W'(IRQ_VEC);
`endif
      r_delta = 2'b01;
      r_we    = 1'b1;
      r_wdata = WIDTH'(pc);
    end else if (is_lit) begin
      t_next  = {1'b0, insn[WIDTH-2:0]};
      d_delta = 2'b01;
      d_we    = 1'b1;
    end else begin
      case (cls)
        CLS_JUMP: pc_next = target;
        CLS_ZBRANCH: begin
          if (t == '0) pc_next = target;
          t_next  = n;
          d_delta = 2'b11;
        end
        CLS_CALL: begin
          pc_next = target;
          r_delta = 2'b01;
          r_we    = 1'b1;
          r_wdata = WIDTH'(pc_plus1);
        end
        default: begin
          t_next  = alu;
          if (insn[BIT_R2PC]) pc_next = r[ADDR_W-1:0];
          d_delta = insn[1:0];
          r_delta = insn[3:2];
          d_we    = insn[BIT_T2N];
          r_we    = insn[BIT_T2R];
        end
      endcase
    end
    if (!retire) pc_next = pc;
  end

  assign imem_addr_o = rst_n ? pc_next : '0;

  // PC, T and bus-stall state; everything holds while a bus access waits.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge sys_clk_i) begin
    if (!rst_n) begin
      pc    <= '0;
      t     <= '0;
      state <= ST_RUN;
    end else begin
      pc    <= pc_next;
      state <= retire ? ST_RUN : ST_WAIT;
      if (retire) t <= t_next;
    end
  end

`ifdef J1X_IRQ_EN
  // Interrupt enable and the call-then-literal guard.
  always_ff @(posedge sys_clk_i) begin
    if (!rst_n) begin
      ie         <= 1'b1;
      after_call <= 1'b0;
    end else begin
      if (irq_take) ie <= 1'b0;
      else if (retire && is_alu && insn[BIT_RETI]) ie <= 1'b1;
      if (retire) after_call <= !irq_take && is_call;
    end
  end
`endif

  j1x_stack #(.WIDTH(WIDTH), .DEPTH_LG2(DSTK_LG2)) u_dstk (
    .clk   (sys_clk_i),
    .rst_n (rst_n),
    .en    (retire),
    .we    (d_we),
    .delta (d_delta),
    .wdata (t),
    .top   (n),
    .ptr   (dsp),
    .ovf   (dstk_ovf_o),
    .unf   (dstk_unf_o)
  );

  j1x_stack #(.WIDTH(WIDTH), .DEPTH_LG2(RSTK_LG2)) u_rstk (
    .clk   (sys_clk_i),
    .rst_n (rst_n),
    .en    (retire),
    .we    (r_we),
    .delta (r_delta),
    .wdata (r_wdata),
    .top   (r),
    .ptr   (rsp),
    .ovf   (rstk_ovf_o),
    .unf   (rstk_unf_o)
  );

endmodule

// File: tb/tb_j1x_core.sv
// Directed testbench for j1x_core (default build, 32-bit, 14-bit addresses,
// 32-entry stacks). Synchronous ROM and a fixed-latency data bus are modelled here.
module tb_j1x_core;
  import j1x_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] imem_addr;
  logic [31:0] imem_data;
  logic [13:0] dbus_addr;
  logic [31:0] dbus_wdata, dbus_rdata;
  logic        dbus_re, dbus_we, dbus_ready;
  logic        dstk_ovf, dstk_unf, rstk_ovf, rstk_unf;
`ifdef J1X_IRQ_EN
  logic        irq = 1'b0;
`endif

  logic [31:0] rom [256];
  logic [31:0] dmem [16];
  int          cnt;
  int          lat = 2;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  j1x_core dut (
    .sys_clk_i    (clk),
    .sys_rst_n_i  (rst_n),
    .imem_addr_o  (imem_addr),
    .imem_data_i  (imem_data),
    .dbus_addr_o  (dbus_addr),
    .dbus_wdata_o (dbus_wdata),
    .dbus_re_o    (dbus_re),
    .dbus_we_o    (dbus_we),
    .dbus_ready_i (dbus_ready),
    .dbus_rdata_i (dbus_rdata),
    .dstk_ovf_o   (dstk_ovf),
    .dstk_unf_o   (dstk_unf),
    .rstk_ovf_o   (rstk_ovf),
    .rstk_unf_o   (rstk_unf)
`ifdef J1X_IRQ_EN
    , .irq_i      (irq)
`endif
  );

  // Synchronous code ROM: data for an address appears after the next edge.
  always @(posedge clk) imem_data <= rom[imem_addr[7:0]];

  // Data memory answering each request after lat wait cycles.
  assign dbus_ready = (dbus_re || dbus_we) && (cnt == lat);
  assign dbus_rdata = dmem[dbus_addr[3:0]];
  always @(posedge clk) begin
    if (!(dbus_re || dbus_we) || dbus_ready) cnt <= 0;
    else cnt <= cnt + 1;
    if (dbus_we && dbus_ready) dmem[dbus_addr[3:0]] <= dbus_wdata;
  end

  function automatic logic [31:0] f_lit(input logic [30:0] v);
    return {1'b1, v};
  endfunction
  function automatic logic [31:0] f_jmp(input logic [13:0] a);
    return {3'b000, 15'd0, a};
  endfunction
  function automatic logic [31:0] f_zbr(input logic [13:0] a);
    return {3'b001, 15'd0, a};
  endfunction
  function automatic logic [31:0] f_call(input logic [13:0] a);
    return {3'b010, 15'd0, a};
  endfunction
  // lo = {T->N, T->R, store, reti, rdelta[1:0], ddelta[1:0]}
  function automatic logic [31:0] f_alu(input logic [3:0] op, input logic r2pc,
                                        input logic [7:0] lo);
    return {3'b011, 16'd0, r2pc, op, lo};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic begin_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = f_jmp(14'(i));
  endtask

  task automatic end_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    begin_reset();
    end_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tick(2);
    check("rst imem_addr", 32'(imem_addr), 32'd0);
    check("rst re/we", {30'd0, dbus_re, dbus_we}, 32'd0);
    check("rst flags", {28'd0, dstk_ovf, dstk_unf, rstk_ovf, rstk_unf}, 32'd0);
    check("rst pc", 32'(dut.pc), 32'd0);
    check("rst T", dut.t, 32'd0);

    // 1: literal 5, literal 7, add with d-1
    begin_reset();
    rom[0] = f_lit(31'd5);
    rom[1] = f_lit(31'd7);
    rom[2] = f_alu(OP_ADD, 1'b0, 8'h03);
    rom[3] = f_jmp(14'd3);
    end_reset();
    tick(3);
    check("add T", dut.t, 32'd12);
    check("add dsp", 32'(dut.dsp), 32'd1);
    check("add N", dbus_wdata, 32'd0);

    // 2: store 0xAA to [3], then load [3], both with two wait cycles
    begin_reset();
    rom[0] = f_lit(31'hAA);
    rom[1] = f_lit(31'd3);
    rom[2] = f_alu(OP_N, 1'b0, 8'h23);
    rom[3] = f_lit(31'd3);
    rom[4] = f_alu(OP_LOAD, 1'b0, 8'h00);
    rom[5] = f_jmp(14'd5);
    end_reset();
    tick(3);
    check("st state", 32'(dut.state), 32'(ST_WAIT));
    check("st we", 32'(dbus_we), 32'd1);
    check("st imem_addr", 32'(imem_addr), 32'd2);
    check("st addr", 32'(dbus_addr), 32'd3);
    check("st wdata", dbus_wdata, 32'hAA);
    tick(2);
    check("st retire T", dut.t, 32'hAA);
    check("st retire dsp", 32'(dut.dsp), 32'd1);
    check("st retire state", 32'(dut.state), 32'(ST_RUN));
    tick(2);
    check("ld state", 32'(dut.state), 32'(ST_WAIT));
    check("ld re", 32'(dbus_re), 32'd1);
    tick(1);
    check("ld wait2", 32'(dut.state), 32'(ST_WAIT));
    tick(1);
    check("ld T", dut.t, 32'hAA);
    check("ld dsp", 32'(dut.dsp), 32'd2);
    check("ld state run", 32'(dut.state), 32'(ST_RUN));

    // Reset during WAIT aborts the store
    begin_reset();
    rom[0] = f_lit(31'h55);
    rom[1] = f_lit(31'd4);
    rom[2] = f_alu(OP_N, 1'b0, 8'h23);
    end_reset();
    tick(3);
    check("abort pre state", 32'(dut.state), 32'(ST_WAIT));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort we", 32'(dbus_we), 32'd0);
    check("abort imem_addr", 32'(imem_addr), 32'd0);
    tick(1);
    check("abort state", 32'(dut.state), 32'(ST_RUN));
    check("abort pc", 32'(dut.pc), 32'd0);

    // 3: call 0x20, return
    begin_reset();
    rom[0]    = f_lit(31'd1);
    rom[1]    = f_call(14'h20);
    rom[2]    = f_jmp(14'd2);
    rom[8'h20] = f_alu(OP_T, 1'b1, 8'h0C);
    end_reset();
    tick(2);
    check("call pc", 32'(dut.pc), 32'h20);
    check("call rsp", 32'(dut.rsp), 32'd1);
    check("call ret addr", 32'(imem_addr), 32'd2);
    tick(1);
    check("ret pc", 32'(dut.pc), 32'd2);
    check("ret rsp", 32'(dut.rsp), 32'd0);
    check("ret T", dut.t, 32'd1);

    // 4: overflow after 32 pushes, underflow on drop at dsp=0
    begin_reset();
    for (int i = 0; i < 33; i++) rom[i] = f_lit(31'(i + 1));
    rom[33] = f_alu(OP_N, 1'b0, 8'h03);
    rom[34] = f_alu(OP_N, 1'b0, 8'h03);
    rom[35] = f_jmp(14'd35);
    end_reset();
    tick(31);
    check("ovf dsp31", 32'(dut.dsp), 32'd31);
    check("ovf before", 32'(dstk_ovf), 32'd0);
    tick(1);
    check("ovf set", 32'(dstk_ovf), 32'd1);
    check("ovf wrap dsp", 32'(dut.dsp), 32'd0);
    tick(1);
    check("ovf sticky", 32'(dstk_ovf), 32'd1);
    check("ovf dsp1", 32'(dut.dsp), 32'd1);
    tick(1);
    check("unf before", 32'(dstk_unf), 32'd0);
    tick(1);
    check("unf set", 32'(dstk_unf), 32'd1);
    check("unf wrap dsp", 32'(dut.dsp), 32'd31);
    check("unf rstk flags", {30'd0, rstk_ovf, rstk_unf}, 32'd0);
    begin_reset();
    end_reset();
    #1;
    check("flags cleared", {30'd0, dstk_ovf, dstk_unf}, 32'd0);

    // 5: 0branch taken on T=0, not taken on T=1, both pop
    begin_reset();
    rom[0]    = f_lit(31'd9);
    rom[1]    = f_lit(31'd0);
    rom[2]    = f_zbr(14'h10);
    rom[8'h10] = f_lit(31'd1);
    rom[8'h11] = f_zbr(14'h30);
    rom[8'h12] = f_jmp(14'h12);
    end_reset();
    tick(3);
    check("zbr taken pc", 32'(dut.pc), 32'h10);
    check("zbr taken T", dut.t, 32'd9);
    check("zbr taken dsp", 32'(dut.dsp), 32'd1);
    tick(2);
    check("zbr fall pc", 32'(dut.pc), 32'h12);
    check("zbr fall T", dut.t, 32'd9);
    check("zbr fall dsp", 32'(dut.dsp), 32'd1);

    // ALU operations: signed/unsigned compare, wrap, shifts mod width, depth, dec
    begin_reset();
    rom[0]  = f_lit(31'd0);
    rom[1]  = f_alu(OP_INV, 1'b0, 8'h00);
    rom[2]  = f_lit(31'd1);
    rom[3]  = f_alu(OP_LT, 1'b0, 8'h00);
    rom[4]  = f_lit(31'd1);
    rom[5]  = f_alu(OP_ULT, 1'b0, 8'h00);
    rom[6]  = f_alu(OP_INV, 1'b0, 8'h00);
    rom[7]  = f_lit(31'd1);
    rom[8]  = f_alu(OP_ADD, 1'b0, 8'h03);
    rom[9]  = f_lit(31'd3);
    rom[10] = f_lit(31'd33);
    rom[11] = f_alu(OP_LSH, 1'b0, 8'h03);
    rom[12] = f_lit(31'd2);
    rom[13] = f_alu(OP_RSH, 1'b0, 8'h03);
    rom[14] = f_alu(OP_DEPTH, 1'b0, 8'h81);
    rom[15] = f_alu(OP_DEC, 1'b0, 8'h00);
    rom[16] = f_jmp(14'd16);
    end_reset();
    tick(4);
    check("lt signed", dut.t, 32'hFFFF_FFFF);
    tick(2);
    check("lt unsigned", dut.t, 32'd0);
    tick(3);
    check("add wrap", dut.t, 32'd0);
    check("add wrap dsp", 32'(dut.dsp), 32'd3);
    tick(3);
    check("lsh mod", dut.t, 32'd6);
    tick(2);
    check("rsh", dut.t, 32'd1);
    tick(1);
    check("depth", dut.t, 32'd4);
    check("depth dsp", 32'(dut.dsp), 32'd5);
    tick(1);
    check("dec", dut.t, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
